// File: rtl/relm_ps2_defs.sv
// Shared definitions for the PS/2 receive path.
//   - frame FSM states
//   - pop_q field positions (retry sits at WD and is placed by the top level)
//   - frame constants and the odd-parity check
package relm_ps2_defs;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_t;

  localparam int unsigned OVF     = 8;
  localparam int unsigned ERR_LSB = 16;
  localparam int unsigned ERR_W   = 8;
  localparam int unsigned NDATA   = 8;

  // Odd parity: data bits plus the parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [NDATA:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/relm_ps2_frame.sv
// PS/2 device-to-host frame receiver.
// Synchronises and glitch-filters the raw PS/2 clock and data pins, deserialises
// 11-bit frames on falling clock edges and checks start, parity and stop bits.
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   ps2_clk_in        raw PS/2 clock pin (asynchronous)
//   ps2_dat_in        raw PS/2 data pin (asynchronous)
//   byte_valid        one-cycle strobe: data_byte holds a good scancode
//   data_byte         received scancode, valid with byte_valid
//   err_pulse         one-cycle strobe: frame rejected or abandoned on timeout
module relm_ps2_frame
  import relm_ps2_defs::*;
#(
  parameter int unsigned WFILT   = 8,
  parameter int unsigned TIMEOUT = 50000,
  parameter int unsigned WTO     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       byte_valid,
  output logic [7:0] data_byte,
  output logic       err_pulse
);

  logic [1:0]       clk_sync;
  logic [1:0]       dat_sync;
  logic [WFILT-1:0] clk_filt;
  logic [WFILT-1:0] dat_filt;
  logic             clk_lvl;
  logic             fall;
  logic             dat_smp;

  ps2_state_t       state, state_nx;
  logic [2:0]       bit_cnt, bit_cnt_nx;
  logic [7:0]       shreg, shreg_nx;
  logic             par, par_nx;
  logic [WTO-1:0]   to_cnt, to_cnt_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_filt <= '1;
      dat_filt <= '1;
      clk_lvl  <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk_in};
      dat_sync <= {dat_sync[0], ps2_dat_in};
      clk_filt <= {clk_filt[WFILT-2:0], clk_sync[1]};
      dat_filt <= {dat_filt[WFILT-2:0], dat_sync[1]};
      if (clk_filt == '0)
        clk_lvl <= 1'b0;
      else if (clk_filt == '1)
        clk_lvl <= 1'b1;
    end
  end

  // The level drops in the cycle after the filter fills with zeros, so the
  // fall event is that cycle itself. The oldest data-filter bit carries the
  // same delay as the oldest clock-filter bit.
  assign fall    = clk_lvl && (clk_filt == '0);
  assign dat_smp = dat_filt[WFILT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      to_cnt  <= '0;
    end else begin
      state   <= state_nx;
      bit_cnt <= bit_cnt_nx;
      shreg   <= shreg_nx;
      par     <= par_nx;
      to_cnt  <= to_cnt_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    shreg_nx   = shreg;
    par_nx     = par;
    to_cnt_nx  = '0;
    byte_valid = 1'b0;
    err_pulse  = 1'b0;

    if (state != ST_IDLE)
      to_cnt_nx = fall ? '0 : to_cnt + 1'b1;

    unique case (state)
      ST_IDLE: begin
        if (fall && !dat_smp) begin
          state_nx   = ST_DATA;
          bit_cnt_nx = '0;
        end
      end
      ST_DATA: begin
        if (fall) begin
          shreg_nx   = {dat_smp, shreg[7:1]};
          bit_cnt_nx = bit_cnt + 3'd1;
          if (bit_cnt == 3'(NDATA - 1))
            state_nx = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (fall) begin
          par_nx   = dat_smp;
          state_nx = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall) begin
          state_nx = ST_IDLE;
          if (dat_smp && odd_parity_ok({shreg, par}))
            byte_valid = 1'b1;
          else
            err_pulse = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase

    if (state != ST_IDLE && !fall && to_cnt == WTO'(TIMEOUT)) begin
      state_nx   = ST_IDLE;
      to_cnt_nx  = '0;
      byte_valid = 1'b0;
      err_pulse  = 1'b1;
    end
  end

  assign data_byte = shreg;

endmodule

// File: rtl/relm_ps2_rx.sv
// PS/2 keyboard receiver with scancode FIFO on a ReLM pop port.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   ps2_clk_in    raw PS/2 clock pin
//   ps2_dat_in    raw PS/2 data pin
//   pop_d         bit WD = pop strobe; lower bits ignored
//   pop_q         bit WD = retry (FIFO empty), [7:0] head scancode,
//                 [8] overflow flag, [23:16] error count, other bits 0
module relm_ps2_rx
  import relm_ps2_defs::*;
#(
  parameter int unsigned WD      = 32,
  parameter int unsigned WAF     = 4,
  parameter int unsigned WFILT   = 8,
  parameter int unsigned TIMEOUT = 50000,
  parameter int unsigned WTO     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk_in,
  input  logic        ps2_dat_in,
  input  logic [WD:0] pop_d,
  output logic [WD:0] pop_q
);

  localparam int unsigned DEPTH = 1 << WAF;

  logic             byte_valid;
  logic [7:0]       data_byte;
  logic             err_pulse;

  logic [7:0]       mem [DEPTH];
  logic [WAF-1:0]   wr_ptr, rd_ptr;
  logic [WAF:0]     count;
  logic             ovf;
  logic [ERR_W-1:0] err_cnt;
  logic             empty, full, push, pop, wr_en;
  logic [WD-1:0]    word;
  logic             unused_pop_bits;

  relm_ps2_frame #(
    .WFILT   (WFILT),
    .TIMEOUT (TIMEOUT),
    .WTO     (WTO)
  ) u_frame (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .byte_valid (byte_valid),
    .data_byte  (data_byte),
    .err_pulse  (err_pulse)
  );

  assign unused_pop_bits = ^pop_d[WD-1:0];

  assign empty = (count == '0);
  assign full  = (count == (WAF+1)'(DEPTH));
  assign push  = byte_valid;
  assign pop   = pop_d[WD] && !empty;
  // When full, a simultaneous pop frees the head slot that wr_ptr points at.
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= data_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      err_cnt <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop)
        count <= count + 1'b1;
      else if (pop && !wr_en)
        count <= count - 1'b1;

      if (push && !wr_en)
        ovf <= 1'b1;
      else if (pop)
        ovf <= 1'b0;

      if (err_pulse && err_cnt != '1)
        err_cnt <= err_cnt + 1'b1;
    end
  end

  always_comb begin
    word = '0;
    if (!empty)
      word[7:0] = mem[rd_ptr];
    word[OVF] = ovf;
    word[ERR_LSB +: ERR_W] = err_cnt;
  end

  assign pop_q = {empty, word};

endmodule

// File: tb/tb_relm_ps2_rx.sv
module tb_relm_ps2_rx;

  localparam int HALF = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ps2_clk_in = 1'b1;
  logic        ps2_dat_in = 1'b1;
  logic [32:0] pop_d = '0;
  logic [32:0] pop_q;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [32:0] EMPTY = {1'b1, 32'h0};

  relm_ps2_rx #(
    .WD      (32),
    .WAF     (4),
    .WFILT   (8),
    .TIMEOUT (5000),
    .WTO     (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .pop_d      (pop_d),
    .pop_q      (pop_q)
  );

  always #10 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic flip_par);
    logic par;
    par = (~^b) ^ flip_par;
    return {1'b1, par, b, 1'b0};
  endfunction

  // Sends the first n bits of f, LSB first, then leaves the clock high.
  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_dat_in = f[i];
      tick(HALF);
      ps2_clk_in = 1'b0;
      tick(HALF);
      ps2_clk_in = 1'b1;
    end
    ps2_dat_in = 1'b1;
    tick(HALF);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic pop_once();
    pop_d = {1'b1, 32'hDEAD_BEEF};
    tick(1);
    pop_d = '0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (pop_q !== EMPTY) begin
      miscompares++;
      $display("FAIL reset: pop_q=%h expected %h", pop_q, EMPTY);
    end
  endtask

  task automatic test_good_frame();
    send_bits(mk_frame(8'h1C, 1'b0), 11);
    vectors++;
    if (pop_q !== {1'b0, 32'h0000_001C}) begin
      miscompares++;
      $display("FAIL good_1c: pop_q=%h expected %h", pop_q, {1'b0, 32'h1C});
    end
    pop_once();
    vectors++;
    if (pop_q !== EMPTY) begin
      miscompares++;
      $display("FAIL pop_to_empty: pop_q=%h expected %h", pop_q, EMPTY);
    end
  endtask

  task automatic test_bad_parity();
    send_bits(mk_frame(8'h1C, 1'b1), 11);
    vectors++;
    if (pop_q !== {1'b1, 32'h0001_0000}) begin
      miscompares++;
      $display("FAIL bad_parity: pop_q=%h expected %h", pop_q, {1'b1, 32'h0001_0000});
    end
  endtask

  task automatic test_timeout();
    do_reset();
    send_bits(mk_frame(8'hF0, 1'b0), 4);
    tick(6000);
    vectors++;
    if (pop_q !== {1'b1, 32'h0001_0000}) begin
      miscompares++;
      $display("FAIL timeout_err: pop_q=%h expected %h", pop_q, {1'b1, 32'h0001_0000});
    end
    send_bits(mk_frame(8'hF0, 1'b0), 11);
    vectors++;
    if (pop_q !== {1'b0, 32'h0001_00F0}) begin
      miscompares++;
      $display("FAIL after_timeout_f0: pop_q=%h expected %h", pop_q, {1'b0, 32'h0001_00F0});
    end
  endtask

  task automatic test_overflow();
    logic [32:0] exp;
    do_reset();
    for (int i = 1; i <= 17; i++)
      send_bits(mk_frame(8'(i), 1'b0), 11);
    for (int i = 1; i <= 16; i++) begin
      exp = {1'b0, 24'h0, 8'(i)};
      if (i == 1)
        exp[8] = 1'b1;
      vectors++;
      if (pop_q !== exp) begin
        miscompares++;
        $display("FAIL overflow_pop%0d: pop_q=%h expected %h", i, pop_q, exp);
      end
      pop_once();
    end
    vectors++;
    if (pop_q !== EMPTY) begin
      miscompares++;
      $display("FAIL overflow_drained: pop_q=%h expected %h", pop_q, EMPTY);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    ps2_dat_in = 1'b0;
    ps2_clk_in = 1'b0;
    tick(3);
    ps2_clk_in = 1'b1;
    tick(20);
    ps2_dat_in = 1'b1;
    pop_once();
    vectors++;
    if (pop_q !== EMPTY) begin
      miscompares++;
      $display("FAIL glitch_empty_pop: pop_q=%h expected %h", pop_q, EMPTY);
    end
    send_bits(mk_frame(8'h66, 1'b0), 11);
    vectors++;
    if (pop_q !== {1'b0, 32'h0000_0066}) begin
      miscompares++;
      $display("FAIL glitch_then_66: pop_q=%h expected %h", pop_q, {1'b0, 32'h66});
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    send_bits(mk_frame(8'h33, 1'b0), 11);
    send_bits(mk_frame(8'h44, 1'b0), 11);
    vectors++;
    if (pop_q !== {1'b0, 32'h0000_0033}) begin
      miscompares++;
      $display("FAIL queued_33: pop_q=%h expected %h", pop_q, {1'b0, 32'h33});
    end
    send_bits(mk_frame(8'h5A, 1'b0), 9);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    vectors++;
    if (pop_q !== EMPTY) begin
      miscompares++;
      $display("FAIL reset_mid: pop_q=%h expected %h", pop_q, EMPTY);
    end
    tick(2);
    send_bits(mk_frame(8'h5A, 1'b0), 11);
    vectors++;
    if (pop_q !== {1'b0, 32'h0000_005A}) begin
      miscompares++;
      $display("FAIL after_reset_5a: pop_q=%h expected %h", pop_q, {1'b0, 32'h5A});
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_parity();
    test_timeout();
    test_overflow();
    test_glitch();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
